cp0_regfile: RTL and testbench
==============================

# cp0_regfile

Coprocessor-0 register file and exception commit point for the MIPS pipeline. It sits in the memory stage directly downstream of the exception-code encoder and consumes that encoder's 5-bit ExcCode. It owns the architectural registers BadVAddr, Count, Compare, Status, Cause and EPC, merges pending interrupts, and drives the pipeline flush and redirect PC. It also services mtc0/mfc0 accesses.

## Interface
- No parameters; all constants live in the shared package.
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- exc_code  in  5  code from the encoder; EXC_NONE = 5'h1f means no exception, EXC_ERET = 5'h1e means eret
- inst_valid  in  1  the memory-stage slot holds a real instruction
- pc_m  in  32  PC of the memory-stage instruction
- in_delay_slot  in  1  that instruction is in a branch delay slot
- bad_addr  in  32  faulting address for AdEL/AdES (fetch or data)
- ext_int  in  6  external hardware interrupts, level-sensitive
- we  in  1  mtc0 write enable
- waddr  in  5  mtc0 register number
- wdata  in  32  mtc0 data
- raddr  in  5  mfc0 register number
- rdata  out  32  mfc0 read data, combinational
- flush  out  1  flush all stages, combinational
- new_pc  out  32  redirect target, valid while flush=1
- status_o, cause_o, epc_o  out  32 each  register views for forwarding/debug
- timer_int  out  1  Cause.TI

## Operation
- Register numbers: BadVAddr = 8, Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14. Any other raddr returns 0.
- Reset values:
  - Status = 32'h0040_0000 (BEV = 1, hardwired).
  - Cause, EPC, BadVAddr, Count and Compare = 0.
  - Outputs: flush = 0, timer_int = 0.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: all 32 bits.
  - BadVAddr: read-only.
  - All other bits read 0.
- Cause.IP[15:10] is updated every cycle to {ext_int[5] | TI, ext_int[4:0]}.
- int_req = IE & ~EXL & |(IP & IM) & inst_valid.
- Committed event, in priority order:
  1. int_req: code 5'h00.
  2. exc_code not in {NONE, ERET} with inst_valid: that code.
  3. exc_code == ERET with inst_valid.
  4. None.
- Exception commit (cases 1–2):
  - flush = 1, new_pc = 32'hBFC0_0380.
  - Next edge: Cause.ExcCode = code, EXL = 1.
  - Only if old EXL == 0: EPC = in_delay_slot ? pc_m − 4 : pc_m, and Cause.BD = in_delay_slot.
  - AdEL/AdES (5'h04/5'h05) also capture BadVAddr = bad_addr.
- ERET commit: flush = 1, new_pc = current EPC. Next edge: EXL = 0.
- Timer:
  - A 1-bit toggle divides clk by 2; Count increments by 1 on the cycles where the toggle is 1.
  - Count wraps from FFFF_FFFF to 0.
  - TI is set when Count == Compare and Compare != 0. An mtc0 to Compare clears TI and has priority over setting it in that cycle.
- Write conflicts:
  - An mtc0 to Count overrides the increment in the same cycle.
  - Exception/eret updates to EXL, EPC, BD, ExcCode and BadVAddr override an mtc0 to the same field in the same cycle.
  - mtc0 is ignored when flush = 1 (the faulting instruction does not commit).

## Timing
- flush and new_pc are combinational from the same-cycle inputs and registers; latency 0.
- Register updates are visible at the next clock edge.
- rdata reflects register state before the current edge. There is no internal write-to-read bypass; same-cycle mtc0/mfc0 forwarding is handled by the pipeline hazard unit.
- Reset asserted mid-operation: all registers return to reset values at that edge and flush is 0 in that cycle. The toggle restarts at 0, so the first increment happens on the second cycle after reset is released.

## Structure
- Shared package (cp0_pkg): CP0 register numbers, ExcCode constants (Int, AdEL, AdES, Sys, Bp, RI, Ov, ERET, NONE), exception vector 32'hBFC0_0380, Status reset value.
- One sub-module: cp0_timer.
  - Contains the toggle, Count and Compare registers and TI.
  - Ports: clk, rst, count write, compare write, wdata; outputs count, compare, ti.
- Everything else stays in cp0_regfile.

## Test plan
- Reset, then read regs 12/13/14/9 -> 32'h0040_0000, 0, 0, 0; flush = 0.
- exc_code = 5'h0c, pc_m = 32'hBFC0_1000, in_delay_slot = 1, inst_valid = 1 -> same-cycle flush = 1, new_pc = BFC0_0380; next cycle EPC = BFC0_0FFC, Cause = 32'h8000_0030, Status.EXL = 1.
- exc_code = 5'h04, bad_addr = 32'h1234_5679 -> BadVAddr = 1234_5679, ExcCode = 4. A second exception while EXL = 1 -> EPC unchanged, ExcCode updated.
- mtc0 Status = 32'h0000_0401, then ext_int[0] = 1 with inst_valid = 1 and exc_code = 5'h08 -> interrupt wins: ExcCode = 0, new_pc = BFC0_0380.
- mtc0 Compare = 5, Count = 0 -> TI = 1 once Count reaches 5 (about 10 cycles). mtc0 Compare = 9 -> TI = 0. With IM7 = 1, IE = 1 -> interrupt taken.
- eret with EPC = 32'hBFC0_0200 -> flush = 1, new_pc = BFC0_0200, EXL = 0 next cycle. A simultaneous mtc0 to Status EXL = 1 is ignored.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, exception codes,
// exception vector and the Status reset image.
package cp0_pkg;

   // CP0 register numbers as seen by mtc0/mfc0
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   // ExcCode values produced by the upstream encoder
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_ERET = 5'h1e;
   localparam logic [4:0] EXC_NONE = 5'h1f;

   // Common exception handler entry (BEV = 1)
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   // BEV is hardwired to 1, everything else clears
   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

   // Address-error exceptions are the only ones that latch BadVAddr
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other clock, TI latches when
// Count reaches a non-zero Compare and is cleared by writing Compare.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic tog;

   // Divide-by-two toggle; restarts at 0 so the first increment is two cycles after reset
   always_ff @(posedge clk) begin
      if (rst) tog <= 1'b0;
      else     tog <= ~tog;
   end

   // Count: software write beats the increment; wraps naturally at 32 bits
   always_ff @(posedge clk) begin
      if (rst)           count <= 32'd0;
      else if (count_we) count <= wdata;
      else if (tog)      count <= count + 32'd1;
   end

   // Compare: software-written only
   always_ff @(posedge clk) begin
      if (rst)             compare <= 32'd0;
      else if (compare_we) compare <= wdata;
   end

   // TI: sticky until Compare is rewritten; the clear wins over a same-cycle match
   always_ff @(posedge clk) begin
      if (rst)                                      ti <= 1'b0;
      else if (compare_we)                          ti <= 1'b0;
      else if ((count == compare) && (compare != 32'd0)) ti <= 1'b1;
   end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception commit point in the memory stage.
// Holds Status/Cause/EPC/BadVAddr, instantiates the Count/Compare timer,
// decides which event commits and drives the flush/redirect.
module cp0_regfile
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  exc_code,
   input  logic        inst_valid,
   input  logic [31:0] pc_m,
   input  logic        in_delay_slot,
   input  logic [31:0] bad_addr,
   input  logic [5:0]  ext_int,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        timer_int
);

   // Status fields
   logic [7:0]  im;
   logic        exl;
   logic        ie;
   // Cause fields
   logic        bd;
   logic [5:0]  ip_hw;
   logic [1:0]  ip_sw;
   logic [4:0]  exccode;
   // Other architectural registers
   logic [31:0] epc;
   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic [7:0]  ip;
   logic        int_req;
   logic        exc_take;
   logic        eret_take;
   logic        mtc0_ok;
   logic [4:0]  commit_code;
   logic [31:0] status;
   logic [31:0] cause;

   // Commit decision: interrupt first, then encoder exception, then eret
   always_comb begin
      ip          = {ip_hw, ip_sw};
      int_req     = ie & ~exl & (|(ip & im)) & inst_valid;
      exc_take    = int_req | (inst_valid & (exc_code != EXC_NONE) & (exc_code != EXC_ERET));
      eret_take   = ~exc_take & inst_valid & (exc_code == EXC_ERET);
      flush       = ~rst & (exc_take | eret_take);
      commit_code = int_req ? EXC_INT : exc_code;
      new_pc      = exc_take ? EXC_VECTOR : epc;
      // A flushed instruction must not commit its mtc0
      mtc0_ok     = we & ~flush;
   end

   // Architectural views assembled from the individual fields
   always_comb begin
      status = STATUS_RESET | {16'd0, im, 6'd0, exl, ie};
      cause  = {bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, exccode, 2'b00};
   end

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_ok && (waddr == REG_COUNT)),
      .compare_we (mtc0_ok && (waddr == REG_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   // Status: mtc0 on IM/EXL/IE, exception sets EXL, eret clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         im  <= 8'd0;
         exl <= 1'b0;
         ie  <= 1'b0;
      end else begin
         if (mtc0_ok && (waddr == REG_STATUS)) begin
            im  <= wdata[15:8];
            exl <= wdata[1];
            ie  <= wdata[0];
         end
         if (exc_take)       exl <= 1'b1;
         else if (eret_take) exl <= 1'b0;
      end
   end

   // Cause: hardware IP sampled every cycle, software IP by mtc0, BD/ExcCode on exception
   always_ff @(posedge clk) begin
      if (rst) begin
         bd      <= 1'b0;
         ip_hw   <= 6'd0;
         ip_sw   <= 2'd0;
         exccode <= 5'd0;
      end else begin
         ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
         if (mtc0_ok && (waddr == REG_CAUSE)) ip_sw <= wdata[9:8];
         if (exc_take) begin
            exccode <= commit_code;
            if (!exl) bd <= in_delay_slot;
         end
      end
   end

   // EPC: nested exceptions (EXL already set) keep the original return address
   always_ff @(posedge clk) begin
      if (rst) begin
         epc <= 32'd0;
      end else begin
         if (mtc0_ok && (waddr == REG_EPC)) epc <= wdata;
         if (exc_take && !exl) epc <= in_delay_slot ? (pc_m - 32'd4) : pc_m;
      end
   end

   // BadVAddr: captured on address-error exceptions only
   always_ff @(posedge clk) begin
      if (rst)                                      badvaddr <= 32'd0;
      else if (exc_take && is_addr_exc(commit_code)) badvaddr <= bad_addr;
   end

   // mfc0 read port, pre-edge register state
   always_comb begin
      case (raddr)
         REG_BADVADDR: rdata = badvaddr;
         REG_COUNT:    rdata = count;
         REG_COMPARE:  rdata = compare;
         REG_STATUS:   rdata = status;
         REG_CAUSE:    rdata = cause;
         REG_EPC:      rdata = epc;
         default:      rdata = 32'd0;
      endcase
   end

   // Debug/forwarding views
   always_comb begin
      status_o  = status;
      cause_o   = cause;
      epc_o     = epc;
      timer_int = ti;
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a register-level model.
module tb_cp0_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  exc_code;
   logic        inst_valid;
   logic [31:0] pc_m;
   logic        in_delay_slot;
   logic [31:0] bad_addr;
   logic [5:0]  ext_int;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] status_o;
   logic [31:0] cause_o;
   logic [31:0] epc_o;
   logic        timer_int;

   int checks = 0;
   int errors = 0;

   cp0_regfile dut (
      .clk(clk), .rst(rst), .exc_code(exc_code), .inst_valid(inst_valid),
      .pc_m(pc_m), .in_delay_slot(in_delay_slot), .bad_addr(bad_addr),
      .ext_int(ext_int), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .flush(flush), .new_pc(new_pc),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .timer_int(timer_int)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (whole 32-bit registers) ----------------
   logic        mdl_ok = 1'b0;
   logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
   logic        m_ti, m_tog;
   logic        m_int, m_exc, m_eret, m_fl;
   logic [4:0]  m_code;
   logic        s_fl, s_exc, s_er, s_ti, s_w;
   logic [4:0]  s_code;
   logic [31:0] s_cnt, s_cmp;

   always_comb begin
      m_int  = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'd0) && inst_valid;
      m_exc  = m_int || (inst_valid && exc_code != 5'h1f && exc_code != 5'h1e);
      m_eret = !m_exc && inst_valid && exc_code == 5'h1e;
      m_fl   = !rst && (m_exc || m_eret);
      m_code = m_int ? 5'h00 : exc_code;
   end

   function automatic logic [31:0] m_cause_full();
      return m_cause | {1'b0, m_ti, 30'd0};
   endfunction

   function automatic logic [31:0] m_rd(input logic [4:0] a);
      case (a)
         5'd8:    return m_bad;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause_full();
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
         m_count = 0; m_compare = 0; m_ti = 0; m_tog = 0; mdl_ok = 1'b1;
      end else if (mdl_ok) begin
         s_fl = m_fl; s_exc = m_exc; s_er = m_eret; s_code = m_code;
         s_ti = m_ti; s_cnt = m_count; s_cmp = m_compare;
         s_w  = we && !s_fl;
         if (s_w && waddr == 5'd11) m_ti = 1'b0;
         else if (s_cnt == s_cmp && s_cmp != 0) m_ti = 1'b1;
         if (s_w && waddr == 5'd9) m_count = wdata;
         else if (m_tog) m_count = s_cnt + 1;
         if (s_w && waddr == 5'd11) m_compare = wdata;
         m_tog = !m_tog;
         if (s_w && waddr == 5'd12) m_status = 32'h0040_0000 | (wdata & 32'h0000_ff03);
         if (s_w && waddr == 5'd13) m_cause = (m_cause & ~32'h300) | (wdata & 32'h300);
         if (s_w && waddr == 5'd14) m_epc = wdata;
         m_cause[15:10] = {ext_int[5] | s_ti, ext_int[4:0]};
         if (s_exc) begin
            if (!m_status[1]) begin
               m_epc = in_delay_slot ? pc_m - 32'd4 : pc_m;
               m_cause[31] = in_delay_slot;
            end
            m_cause[6:2] = s_code;
            m_status[1]  = 1'b1;
            if (s_code == 5'h04 || s_code == 5'h05) m_bad = bad_addr;
         end else if (s_er) begin
            m_status[1] = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("flush", {31'd0, flush}, {31'd0, m_fl});
         if (m_fl) chk("new_pc", new_pc, m_exc ? 32'hBFC0_0380 : m_epc);
         chk("rdata", rdata, m_rd(raddr));
         chk("status_o", status_o, m_status);
         chk("cause_o", cause_o, m_cause_full());
         chk("epc_o", epc_o, m_epc);
         chk("timer_int", {31'd0, timer_int}, {31'd0, m_ti});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_valid = 0; exc_code = 5'h1f; we = 0; waddr = 0; wdata = 0;
      ext_int = 0; in_delay_slot = 0; pc_m = 32'h8000_0000; bad_addr = 0;
   endtask

   logic        seen;
   logic [4:0]  wsel [7];
   logic [4:0]  esel [8];
   int          r;

   initial begin
      wsel = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      esel = '{5'h1e, 5'h04, 5'h05, 5'h08, 5'h0c, 5'h0d, 5'h0a, 5'h09};
      idle(); raddr = 0; rst = 1;
      step();
      exc_code = 5'h0c; inst_valid = 1;
      #2 chk("flush_in_reset", {31'd0, flush}, 32'd0);
      step();
      rst = 0; idle();
      raddr = 12; #1 chk("rst_status", rdata, 32'h0040_0000);
      raddr = 13; #1 chk("rst_cause", rdata, 32'd0);
      raddr = 14; #1 chk("rst_epc", rdata, 32'd0);
      raddr = 9;  #1 chk("rst_count", rdata, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);

      // Exception in a delay slot
      step();
      exc_code = 5'h0c; pc_m = 32'hBFC0_1000; in_delay_slot = 1; inst_valid = 1;
      #2 chk("ov_flush", {31'd0, flush}, 32'd1);
      chk("ov_new_pc", new_pc, 32'hBFC0_0380);
      step(); idle();
      #2 chk("ov_epc", epc_o, 32'hBFC0_0FFC);
      chk("ov_cause", cause_o, 32'h8000_0030);
      chk("ov_status", status_o, 32'h0040_0002);

      // Nested address error: BadVAddr captured, EPC kept
      exc_code = 5'h04; bad_addr = 32'h1234_5679; pc_m = 32'h8000_0100; inst_valid = 1;
      step(); idle(); raddr = 8;
      #2 chk("adel_badvaddr", rdata, 32'h1234_5679);
      chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
      chk("adel_epc_kept", epc_o, 32'hBFC0_0FFC);

      // Interrupt beats a syscall
      we = 1; waddr = 12; wdata = 32'h0000_0401;
      step(); idle();
      #2 chk("mtc0_status", status_o, 32'h0040_0401);
      ext_int = 6'b000001;
      step();
      inst_valid = 1; exc_code = 5'h08; pc_m = 32'h8000_0200;
      #2 chk("int_flush", {31'd0, flush}, 32'd1);
      chk("int_new_pc", new_pc, 32'hBFC0_0380);
      step(); idle();
      #2 chk("int_exccode", {27'd0, cause_o[6:2]}, 32'd0);
      chk("int_status", status_o, 32'h0040_0403);
      chk("int_epc", epc_o, 32'h8000_0200);

      // Timer: Compare = 5, Count = 0
      we = 1; waddr = 11; wdata = 5;
      step();
      waddr = 9; wdata = 0;
      step(); idle(); raddr = 9;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #2 if (timer_int) seen = 1; else step();
      end
      chk("ti_rise", {31'd0, seen}, 32'd1);
      chk("count_at_ti", {31'd0, (rdata == 5 || rdata == 6)}, 32'd1);
      step();
      we = 1; waddr = 11; wdata = 9;
      step(); idle();
      #2 chk("ti_clear", {31'd0, timer_int}, 32'd0);
      we = 1; waddr = 12; wdata = 32'h0000_8001;
      step(); idle();
      inst_valid = 1;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         #2 if (flush) seen = 1; else step();
      end
      chk("timer_int_taken", {31'd0, seen}, 32'd1);
      chk("timer_int_pc", new_pc, 32'hBFC0_0380);
      step(); idle();
      #2 chk("timer_exccode", {27'd0, cause_o[6:2]}, 32'd0);

      // eret with a conflicting mtc0 to Status
      we = 1; waddr = 14; wdata = 32'hBFC0_0200;
      step(); idle();
      inst_valid = 1; exc_code = 5'h1e; we = 1; waddr = 12; wdata = 32'h0000_8003;
      #2 chk("eret_flush", {31'd0, flush}, 32'd1);
      chk("eret_new_pc", new_pc, 32'hBFC0_0200);
      step(); idle();
      #2 chk("eret_status", status_o, 32'h0040_8001);

      // Randomized traffic, occasional mid-run reset
      rst = 1; step(); rst = 0;
      for (int n = 0; n < 4000; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         inst_valid = ($urandom_range(0, 3) != 0);
         r          = $urandom_range(0, 15);
         exc_code   = (r < 8) ? 5'h1f : esel[r - 8];
         pc_m       = $urandom & 32'hFFFF_FFFC;
         in_delay_slot = $urandom_range(0, 1) == 1;
         bad_addr   = $urandom;
         ext_int    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
         we         = ($urandom_range(0, 2) == 0);
         waddr      = wsel[$urandom_range(0, 6)];
         wdata      = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         raddr      = wsel[$urandom_range(0, 6)];
         step();
      end
      rst = 0; idle();
      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
